imem_loader: RTL and testbench

Boot-time program loader that writes the instruction memory the pipeline fetches from. It sits between a byte-stream receiver (UART RX style: one-cycle valid strobe per byte) and the instruction memory write port. It assembles big-endian 32-bit words from a framed byte stream and writes them at consecutive word addresses from 0. It holds the pipeline in reset/stall via `cpu_hold` until a complete, checksum-valid image is loaded.

---
 rtl/imem_loader.sv | 151 +++++++++++++++
 tb/tb_imem_loader.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
// Boot-time instruction memory loader: assembles big-endian words from a framed,
// XOR-checksummed byte stream and holds the CPU until a valid image is in place.
module imem_loader #(
   parameter int ADDR_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  rx_valid,
   input  logic [7:0]            rx_data,
   input  logic                  load_req,
   output logic                  mem_we,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [31:0]           mem_wdata,
   output logic                  cpu_hold,
   output logic                  load_done,
   output logic                  err
);

   localparam logic [2:0] ST_LEN_HI = 3'd0;
   localparam logic [2:0] ST_LEN_LO = 3'd1;
   localparam logic [2:0] ST_DATA   = 3'd2;
   localparam logic [2:0] ST_CHK    = 3'd3;
   localparam logic [2:0] ST_RUN    = 3'd4;
   localparam logic [2:0] ST_ERR    = 3'd5;

   localparam logic [16:0]         DEPTH_C    = 17'd1 << ADDR_WIDTH;
   localparam logic [ADDR_WIDTH:0] WORD_ONE_C = (ADDR_WIDTH+1)'(1);

   logic [2:0]            state_r;
   logic [7:0]            len_hi_r;
   logic [ADDR_WIDTH:0]   n_r;
   logic [1:0]            byte_cnt_r;
   logic [ADDR_WIDTH:0]   wcnt_r;
   logic [7:0]            xor_r;
   logic [23:0]           word_r;
   logic                  mem_we_r;
   logic [ADDR_WIDTH-1:0] mem_addr_r;
   logic [31:0]           mem_wdata_r;
   logic                  cpu_hold_r;
   logic                  load_done_r;
   logic                  err_r;

   logic [15:0]           len_s;
   logic [ADDR_WIDTH:0]   wcnt_next_s;

   function automatic logic [7:0] chk_accum(input logic [7:0] acc, input logic [7:0] b);
      return acc ^ b;
   endfunction

   assign len_s       = {len_hi_r, rx_data};
   assign wcnt_next_s = wcnt_r + WORD_ONE_C;

   // Frame parser, word assembly and all registered outputs
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r     <= ST_LEN_HI;
         len_hi_r    <= 8'd0;
         n_r         <= '0;
         byte_cnt_r  <= 2'd0;
         wcnt_r      <= '0;
         xor_r       <= 8'd0;
         word_r      <= 24'd0;
         mem_we_r    <= 1'b0;
         mem_addr_r  <= '0;
         mem_wdata_r <= 32'd0;
         cpu_hold_r  <= 1'b1;
         load_done_r <= 1'b0;
         err_r       <= 1'b0;
      end else begin
         mem_we_r    <= 1'b0;
         load_done_r <= 1'b0;
         case (state_r)
            ST_LEN_HI: begin
               if (rx_valid) begin
                  len_hi_r <= rx_data;
                  state_r  <= ST_LEN_LO;
               end
            end
            ST_LEN_LO: begin
               if (rx_valid) begin
                  byte_cnt_r <= 2'd0;
                  wcnt_r     <= '0;
                  xor_r      <= 8'd0;
                  n_r        <= (ADDR_WIDTH+1)'(len_s);
                  if ({1'b0, len_s} > DEPTH_C) begin
                     state_r <= ST_ERR;
                     err_r   <= 1'b1;
                  end else if (len_s == 16'd0) begin
                     state_r <= ST_CHK;
                  end else begin
                     state_r <= ST_DATA;
                  end
               end
            end
            ST_DATA: begin
               if (rx_valid) begin
                  xor_r      <= chk_accum(xor_r, rx_data);
                  word_r     <= {word_r[15:0], rx_data};
                  byte_cnt_r <= byte_cnt_r + 2'd1;
                  // Fourth byte completes the word; counter wraps to 0 by itself
                  if (byte_cnt_r == 2'd3) begin
                     mem_we_r    <= 1'b1;
                     mem_addr_r  <= wcnt_r[ADDR_WIDTH-1:0];
                     mem_wdata_r <= {word_r, rx_data};
                     wcnt_r      <= wcnt_next_s;
                     if (wcnt_next_s == n_r) begin
                        state_r <= ST_CHK;
                     end
                  end
               end
            end
            ST_CHK: begin
               if (rx_valid) begin
                  if (rx_data == xor_r) begin
                     state_r     <= ST_RUN;
                     load_done_r <= 1'b1;
                     cpu_hold_r  <= 1'b0;
                  end else begin
                     state_r <= ST_ERR;
                     err_r   <= 1'b1;
                  end
               end
            end
            ST_RUN: begin
               if (load_req) begin
                  state_r    <= ST_LEN_HI;
                  cpu_hold_r <= 1'b1;
               end
            end
            ST_ERR: begin
               if (load_req) begin
                  state_r <= ST_LEN_HI;
                  err_r   <= 1'b0;
               end
            end
            default: begin
               state_r    <= ST_LEN_HI;
               cpu_hold_r <= 1'b1;
            end
         endcase
      end
   end

   assign mem_we    = mem_we_r;
   assign mem_addr  = mem_addr_r;
   assign mem_wdata = mem_wdata_r;
   assign cpu_hold  = cpu_hold_r;
   assign load_done = load_done_r;
   assign err       = err_r;

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: directed frames plus randomized frames checked against a
// frame-level reference model (writes, load_done count, final err/cpu_hold).
module tb_imem_loader;

   localparam int AW    = 8;
   localparam int DEPTH = 1 << AW;

   logic          clk = 1'b0;
   logic          reset;
   logic          rx_valid;
   logic [7:0]    rx_data;
   logic          load_req;
   logic          mem_we;
   logic [AW-1:0] mem_addr;
   logic [31:0]   mem_wdata;
   logic          cpu_hold;
   logic          load_done;
   logic          err;

   always #5 clk = ~clk;

   imem_loader #(.ADDR_WIDTH(AW)) dut (
      .clk       (clk),
      .reset     (reset),
      .rx_valid  (rx_valid),
      .rx_data   (rx_data),
      .load_req  (load_req),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .cpu_hold  (cpu_hold),
      .load_done (load_done),
      .err       (err)
   );

   int          n_checks = 0;
   int          n_errors = 0;
   int          got_addr[$];
   logic [31:0] got_data[$];
   int          done_total = 0;
   int          exp_addr[$];
   logic [31:0] exp_data[$];
   int          exp_done;
   logic        exp_err;
   logic        exp_hold;
   logic [7:0]  frm[$];

   // Monitor: record every memory write and every load_done cycle
   always @(negedge clk) begin
      if (mem_we) begin
         got_addr.push_back(int'(mem_addr));
         got_data.push_back(mem_wdata);
      end
      if (load_done) done_total++;
   end

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic idle();
      @(posedge clk);
      #1;
   endtask

   task automatic send_byte(input logic [7:0] b);
      rx_valid = 1'b1;
      rx_data  = b;
      @(posedge clk);
      #1;
      rx_valid = 1'b0;
   endtask

   task automatic restart();
      load_req = 1'b1;
      @(posedge clk);
      #1;
      load_req = 1'b0;
      check_val("req_hold", cpu_hold, 32'd1);
      check_val("req_err", err, 32'd0);
   endtask

   // Frame-level reference: what a whole frame must produce
   task automatic model_frame();
      int         n;
      logic [7:0] x;
      exp_addr.delete();
      exp_data.delete();
      n = int'({frm[0], frm[1]});
      if (n > DEPTH) begin
         exp_done = 0; exp_err = 1'b1; exp_hold = 1'b1;
      end else begin
         x = 8'd0;
         for (int i = 0; i < n; i++) begin
            exp_addr.push_back(i);
            exp_data.push_back({frm[2+4*i], frm[3+4*i], frm[4+4*i], frm[5+4*i]});
         end
         for (int j = 2; j < 2 + 4*n; j++) x = x ^ frm[j];
         if (frm[2+4*n] == x) begin
            exp_done = 1; exp_err = 1'b0; exp_hold = 1'b0;
         end else begin
            exp_done = 0; exp_err = 1'b1; exp_hold = 1'b1;
         end
      end
   endtask

   task automatic compare(input string tag, input int wb, input int db);
      check_val({tag, ":nwr"}, got_addr.size() - wb, exp_addr.size());
      for (int i = 0; i < exp_addr.size(); i++) begin
         if (wb + i < got_addr.size()) begin
            check_val({tag, ":addr"}, got_addr[wb+i], exp_addr[i]);
            check_val({tag, ":data"}, got_data[wb+i], exp_data[i]);
         end
      end
      check_val({tag, ":done"}, done_total - db, exp_done);
      check_val({tag, ":err"}, err, exp_err);
      check_val({tag, ":hold"}, cpu_hold, exp_hold);
   endtask

   task automatic run_frame(input string tag, input int max_gap);
      int wb = got_addr.size();
      int db = done_total;
      model_frame();
      for (int i = 0; i < frm.size(); i++) begin
         if (max_gap > 0) repeat ($urandom_range(max_gap, 0)) idle();
         send_byte(frm[i]);
      end
      repeat (2) idle();
      compare(tag, wb, db);
   endtask

   task automatic build_random(input int n, input bit bad);
      logic [7:0] x = 8'd0;
      logic [7:0] b;
      logic [15:0] n16 = 16'(n);
      frm.delete();
      frm.push_back(n16[15:8]);
      frm.push_back(n16[7:0]);
      for (int i = 0; i < 4*n; i++) begin
         b = 8'($urandom);
         frm.push_back(b);
         x = x ^ b;
      end
      frm.push_back(bad ? (x ^ 8'h5A) : x);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int wb;
      int db;
      reset = 1'b1; rx_valid = 1'b0; rx_data = 8'd0; load_req = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
      check_val("rst_hold", cpu_hold, 32'd1);
      check_val("rst_we", mem_we, 32'd0);
      check_val("rst_addr", mem_addr, 32'd0);
      check_val("rst_wdata", mem_wdata, 32'd0);
      check_val("rst_done", load_done, 32'd0);
      check_val("rst_err", err, 32'd0);

      // Nominal frame with cycle-level latency checks
      frm = {8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05, 8'h20, 8'h09, 8'h00, 8'h0A, 8'h0E};
      wb = got_addr.size();
      db = done_total;
      model_frame();
      for (int i = 0; i < frm.size(); i++) begin
         send_byte(frm[i]);
         if (i == 5) begin
            check_val("w0_we", mem_we, 32'd1);
            check_val("w0_addr", mem_addr, 32'd0);
            check_val("w0_data", mem_wdata, 32'h20080005);
         end
         if (i == 6) begin
            check_val("w0_we_once", mem_we, 32'd0);
            check_val("w0_data_hold", mem_wdata, 32'h20080005);
         end
         if (i == 10) begin
            check_val("nom_done_now", load_done, 32'd1);
            check_val("nom_hold_now", cpu_hold, 32'd0);
         end
      end
      idle();
      check_val("nom_done_pulse", load_done, 32'd0);
      check_val("nom_addr_hold", mem_addr, 32'd1);
      idle();
      compare("nominal", wb, db);

      // Bad checksum, then recovery
      restart();
      frm = {8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05, 8'h20, 8'h09, 8'h00, 8'h0A, 8'h0F};
      run_frame("badchk", 0);
      restart();
      frm = {8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05, 8'h20, 8'h09, 8'h00, 8'h0A, 8'h0E};
      run_frame("reload", 0);

      restart();
      frm = {8'h00, 8'h00, 8'h00};
      run_frame("empty", 0);

      // Oversize length, trailing bytes ignored, then exactly DEPTH words
      restart();
      wb = got_addr.size();
      db = done_total;
      send_byte(8'h01);
      send_byte(8'h01);
      check_val("over_err_now", err, 32'd1);
      for (int i = 0; i < 4; i++) send_byte(8'($urandom));
      idle();
      check_val("over_nwr", got_addr.size() - wb, 32'd0);
      check_val("over_err_sticky", err, 32'd1);
      check_val("over_done", done_total - db, 32'd0);
      restart();
      build_random(DEPTH, 1'b0);
      run_frame("full", 0);

      // Reset in the middle of a word
      restart();
      wb = got_addr.size();
      send_byte(8'h00); send_byte(8'h01); send_byte(8'hAA); send_byte(8'hBB); send_byte(8'hCC);
      reset = 1'b1;
      idle();
      reset = 1'b0;
      repeat (2) idle();
      check_val("mid_rst_nwr", got_addr.size() - wb, 32'd0);
      check_val("mid_rst_addr", mem_addr, 32'd0);
      check_val("mid_rst_hold", cpu_hold, 32'd1);
      frm = {8'h00, 8'h01, 8'h11, 8'h22, 8'h33, 8'h44, 8'h44};
      run_frame("after_reset", 0);

      // RUN ignores bytes; load_req beats a coincident byte
      wb = got_addr.size();
      for (int i = 0; i < 3; i++) send_byte(8'($urandom));
      idle();
      check_val("run_nwr", got_addr.size() - wb, 32'd0);
      check_val("run_hold", cpu_hold, 32'd0);
      load_req = 1'b1; rx_valid = 1'b1; rx_data = 8'h00;
      @(posedge clk);
      #1;
      load_req = 1'b0; rx_valid = 1'b0;
      check_val("coinc_hold", cpu_hold, 32'd1);
      build_random(3, 1'b0);
      run_frame("post_drop", 2);

      // Random frames, each sent back-to-back and then with random gaps
      for (int k = 0; k < 12; k++) begin
         build_random($urandom_range(6, 0), ($urandom_range(3, 0) == 0));
         restart();
         run_frame("rnd_b2b", 0);
         restart();
         run_frame("rnd_gap", 4);
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
